// File: rtl/dec24_strobe.sv
// Sequenced 2-to-4 one-hot decoder: accepts a 2-bit code over valid/ready,
// drives the matching one-hot line for HOLD cycles, then idles GAP cycles.
module dec24_strobe #(
  parameter int HOLD = 2,
  parameter int GAP  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] code,
  input  logic       clr,
  output logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int MAXV    = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW      = $clog2(MAXV + 1);
  localparam int GAP_M1I = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(GAP_M1I);
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    y_nxt;

  // Handshake: a code is taken at a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state and clr, never on in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      y     <= 4'b0000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      y     <= y_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    y_nxt     = y;
    if (clr) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      y_nxt     = 4'b0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_nxt = S_DRIVE;
            cnt_nxt   = HOLD_M1;
            y_nxt     = 4'b0001 << code;
          end
        end
        S_DRIVE: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            y_nxt = 4'b0000;
            if (HAS_GAP) begin
              state_nxt = S_GAP;
              cnt_nxt   = GAP_M1;
            end else begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CW'(1);
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          y_nxt     = 4'b0000;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && !clr;
    busy      = (state != S_IDLE);
    done      = (state == S_DRIVE) && (cnt == '0) && !clr;
    dbg_state = state;
  end

endmodule
